// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join controller: join modes, FSM states, mode decode.
package fork_join_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ALL  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ANY  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_NONE = 2'd2;

  typedef enum logic [MODE_W-1:0] {
    JOIN_ALL  = MODE_ALL,
    JOIN_ANY  = MODE_ANY,
    JOIN_NONE = MODE_NONE
  } join_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN
  } state_e;

  // The reserved encoding 3 falls back to join_all.
  function automatic join_mode_e decode_mode(input logic [MODE_W-1:0] raw);
    case (raw)
      MODE_ANY:  return JOIN_ANY;
      MODE_NONE: return JOIN_NONE;
      default:   return JOIN_ALL;
    endcase
  endfunction

endpackage

// File: rtl/fork_join_ctrl_first_done_enc.sv
// Lowest-index priority encoder used to pick the first finishing worker.
module first_done_enc #(
  parameter int unsigned N_WORKERS = 2,
  parameter int unsigned ID_W      = $clog2(N_WORKERS)
) (
  input  logic [N_WORKERS-1:0] req,
  output logic [ID_W-1:0]      idx,
  output logic                 any
);

  always_comb begin
    idx = '0;
    for (int i = int'(N_WORKERS) - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches all workers on a fork and releases the
// requester according to the latched join mode, tracking stragglers afterwards.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int unsigned N_WORKERS = 2,
  parameter int unsigned ID_W      = $clog2(N_WORKERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fork_valid,
  input  logic [1:0]           fork_mode,
  output logic                 fork_ready,
  output logic [N_WORKERS-1:0] start,
  input  logic [N_WORKERS-1:0] done,
  output logic                 proceed,
  output logic [ID_W-1:0]      first_id,
  output logic [N_WORKERS-1:0] pending,
  output logic                 busy,
  output logic                 err_spurious
);

  localparam logic [N_WORKERS-1:0] ALL_ONES = '1;

  state_e               state_q, state_d;
  join_mode_e           mode_q, mode_d, fork_mode_dec;
  logic [N_WORKERS-1:0] pending_q, pending_d;
  logic [N_WORKERS-1:0] start_q, start_d;
  logic [N_WORKERS-1:0] hit, remaining;
  logic                 proceed_q, proceed_d;
  logic                 err_spurious_q, err_spurious_d;
  logic [ID_W-1:0]      first_id_q, first_id_d;
  logic [ID_W-1:0]      enc_idx;
  logic                 enc_any;
  logic                 first_hit;

  assign hit           = done & pending_q;
  assign remaining     = pending_q & ~done;
  // Pending only drops from all-ones on the very first completion of a job.
  assign first_hit     = (pending_q == ALL_ONES) && enc_any;
  assign fork_mode_dec = decode_mode(fork_mode);

  first_done_enc #(
    .N_WORKERS (N_WORKERS),
    .ID_W      (ID_W)
  ) u_enc (
    .req (hit),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    pending_d      = pending_q;
    start_d        = '0;
    proceed_d      = 1'b0;
    first_id_d     = first_id_q;
    err_spurious_d = |(done & ~pending_q);

    case (state_q)
      S_IDLE: begin
        if (fork_valid) begin
          mode_d     = fork_mode_dec;
          pending_d  = ALL_ONES;
          start_d    = ALL_ONES;
          first_id_d = '0;
          proceed_d  = (fork_mode_dec == JOIN_NONE);
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH, S_WAIT: begin
        pending_d = remaining;
        if (first_hit && mode_q != JOIN_NONE) first_id_d = enc_idx;
        case (mode_q)
          JOIN_NONE: state_d = (remaining == '0) ? S_IDLE : S_DRAIN;
          JOIN_ANY: begin
            if (first_hit) begin
              proceed_d = 1'b1;
              state_d   = (remaining == '0) ? S_IDLE : S_DRAIN;
            end else begin
              state_d = S_WAIT;
            end
          end
          default: begin
            if (remaining == '0) begin
              proceed_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_WAIT;
            end
          end
        endcase
      end
      S_DRAIN: begin
        pending_d = remaining;
        if (remaining == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mode_q         <= JOIN_ALL;
      pending_q      <= '0;
      start_q        <= '0;
      proceed_q      <= 1'b0;
      first_id_q     <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      pending_q      <= pending_d;
      start_q        <= start_d;
      proceed_q      <= proceed_d;
      first_id_q     <= first_id_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign fork_ready   = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign start        = start_q;
  assign proceed      = proceed_q;
  assign first_id     = first_id_q;
  assign pending      = pending_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Randomized bench for fork_join_ctrl; the reference model schedules each fork
// by absolute completion cycles and derives every output from them.
module tb_fork_join_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          fork_valid;
  logic [1:0]    fork_mode;
  logic          fork_ready;
  logic [N-1:0]  start;
  logic [N-1:0]  done;
  logic          proceed;
  logic [IW-1:0] first_id;
  logic [N-1:0]  pending;
  logic          busy;
  logic          err_spurious;

  always #5 clk = ~clk;

  fork_join_ctrl #(.N_WORKERS(N), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fork_valid   (fork_valid),
    .fork_mode    (fork_mode),
    .fork_ready   (fork_ready),
    .start        (start),
    .done         (done),
    .proceed      (proceed),
    .first_id     (first_id),
    .pending      (pending),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference state: the active job as absolute cycle numbers.
  int t_fork;
  int dc[N];
  int ghost[N];
  int pc;
  int fid;
  bit spur_prev;
  int n_forks = 0;

  int pq_mode[$];
  int pq_gap[$];
  int pq_off[$];
  int cur_mode, cur_gap;
  int cur_off[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_plan(input int m, input int g, input int o0, input int o1,
                           input int o2, input int o3);
    pq_mode.push_back(m);
    pq_gap.push_back(g);
    pq_off.push_back(o0);
    pq_off.push_back(o1);
    pq_off.push_back(o2);
    pq_off.push_back(o3);
  endtask

  task automatic load_plan();
    if (pq_mode.size() > 0) begin
      cur_mode = pq_mode.pop_front();
      cur_gap  = pq_gap.pop_front();
      for (int i = 0; i < N; i++) cur_off[i] = pq_off.pop_front();
    end else begin
      cur_mode = int'($urandom_range(3));
      cur_gap  = int'($urandom_range(3));
      for (int i = 0; i < N; i++) cur_off[i] = int'($urandom_range(12, 1));
    end
  endtask

  task automatic step(input bit do_rst);
    logic [N-1:0] e_pend, e_start, dv;
    bit           e_ready, e_proc, e_err, spur_next, fv;
    logic [1:0]   fm;
    int           maxd, mind, e_fid, j, md;
    @(posedge clk);
    #1;
    cyc++;
    if (do_rst) begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        ghost[i] = dc[i];
        dc[i]    = -100;
      end
      t_fork    = -100;
      pc        = -100;
      fid       = 0;
      spur_prev = 1'b0;
    end else begin
      rst = 1'b0;
    end

    maxd = -1000;
    for (int i = 0; i < N; i++) if (dc[i] > maxd) maxd = dc[i];
    e_ready = !(cyc >= t_fork + 1 && cyc <= maxd);
    e_start = (cyc == t_fork + 1) ? {N{1'b1}} : {N{1'b0}};
    for (int i = 0; i < N; i++) e_pend[i] = (cyc >= t_fork + 1) && (dc[i] >= cyc);
    e_proc = (cyc == pc);
    e_fid  = fid;
    e_err  = spur_prev;

    dv = '0;
    fv = 1'b0;
    fm = 2'($urandom_range(3));
    if (!do_rst) begin
      for (int i = 0; i < N; i++) if (dc[i] == cyc || ghost[i] == cyc) dv[i] = 1'b1;
      if ($urandom_range(5) == 0) begin
        j = int'($urandom_range(N - 1));
        if (!e_pend[j]) dv[j] = 1'b1;
      end
      if (e_ready && cur_gap > 0) begin
        cur_gap--;
      end else if (cur_gap == 0) begin
        fv = 1'b1;
        fm = 2'(cur_mode);
      end else begin
        fv = 1'($urandom_range(1));
      end
      if (fv && e_ready) begin
        t_fork = cyc;
        n_forks++;
        mind = 1 << 30;
        maxd = -1000;
        for (int i = 0; i < N; i++) begin
          dc[i] = cyc + cur_off[i];
          if (dc[i] < mind) mind = dc[i];
          if (dc[i] > maxd) maxd = dc[i];
        end
        md = (cur_mode == 3) ? 0 : cur_mode;
        if (md == 2) begin
          pc  = cyc + 1;
          fid = 0;
        end else begin
          pc  = (md == 1) ? mind + 1 : maxd + 1;
          fid = 0;
          for (int i = N - 1; i >= 0; i--) if (dc[i] == mind) fid = i;
        end
        load_plan();
      end
    end
    spur_next  = do_rst ? 1'b0 : |(dv & ~e_pend);
    fork_valid = fv;
    fork_mode  = fm;
    done       = dv;
    spur_prev  = spur_next;

    @(negedge clk);
    check("fork_ready", 32'(fork_ready), 32'(e_ready));
    check("busy", 32'(busy), 32'(!e_ready));
    check("start", 32'(start), 32'(e_start));
    check("pending", 32'(pending), 32'(e_pend));
    check("proceed", 32'(proceed), 32'(e_proc));
    check("err_spurious", 32'(err_spurious), 32'(e_err));
    if (e_proc || do_rst) check("first_id", 32'(first_id), 32'(e_fid));
  endtask

  initial begin
    int target;
    int k;
    rst        = 1'b1;
    fork_valid = 1'b0;
    fork_mode  = 2'd0;
    done       = '0;
    t_fork     = -100;
    pc         = -100;
    fid        = 0;
    spur_prev  = 1'b0;
    for (int i = 0; i < N; i++) begin
      dc[i]    = -100;
      ghost[i] = -100;
    end

    push_plan(1, 0, 20, 30, 30, 30);
    push_plan(0, 2, 20, 30, 30, 30);
    push_plan(2, 0, 5, 6, 7, 8);
    push_plan(1, 1, 12, 12, 10, 10);
    push_plan(3, 0, 3, 1, 2, 4);
    push_plan(0, 0, 1, 1, 1, 1);
    push_plan(1, 3, 1, 5, 5, 5);
    load_plan();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fork_ready", 32'(fork_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_proceed", 32'(proceed), 32'd0);
    check("rst_first_id", 32'(first_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_spurious), 32'd0);

    for (k = 0; k < 20000 && n_forks < 90; k++) step(1'b0);
    check("fork_progress", 32'(n_forks >= 90), 32'd1);

    // Reset in the middle of a join_all wait; in-flight workers then finish.
    push_plan(0, 0, 25, 18, 30, 40);
    push_plan(1, 45, 2, 3, 4, 5);
    target = n_forks + 2;
    for (k = 0; k < 2000 && !(n_forks == target && cyc == t_fork + 14); k++) step(1'b0);
    check("reset_setup", 32'(n_forks == target && cyc == t_fork + 14), 32'd1);
    step(1'b1);
    repeat (120) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
